universal_reg: RTL and testbench
================================

Name: universal_reg

Overview:
- Parametrised, clocked N-bit register; next generation of the single-bit d_ff storage element.
- Adds synchronous reset, enable, parallel load, shift, rotate and up/down count modes.
- Provides a registered carry/serial-out bit.
- Building block for lab datapaths: shift registers, counters, accumulators' holding registers.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RESET_VALUE, 0, value loaded into q on reset (WIDTH bits, truncated if wider).

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-high reset; highest priority.
- en  input  1  operation enable; 0 = hold regardless of mode.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- sl_in  input  1  serial input entering bit 0 on shift-left.
- sr_in  input  1  serial input entering bit WIDTH-1 on shift-right.
- q  output  WIDTH  registered state.
- q_bar  output  WIDTH  bitwise complement of q, combinational from q.
- cout  output  1  registered carry / serial-out bit.
- zero  output  1  combinational, 1 when q == 0.

Behaviour:
- Clock and reset:
  - One clock domain.
  - reset is synchronous and active-high; it is sampled only at posedge clk.
  - When reset=1 at an edge: q <= RESET_VALUE and cout <= 0, regardless of en, mode and other inputs.
  - Asserting reset mid-operation (mid-count, mid-shift) aborts that operation at the same edge. No partial update occurs.
  - Outputs are not defined before the first reset edge. The bench must apply reset first.
- Enable:
  - reset=0, en=0: q and cout hold their values. Mode is ignored.
- Mode encoding (reset=0, en=1). All updates take effect at the edge (1-cycle latency); q shows the new value right after the edge.
  - 000 HOLD: q unchanged; cout <= 0.
  - 001 LOAD: q <= d; cout <= 0.
  - 010 SHL: q <= {q[WIDTH-2:0], sl_in}; cout <= old q[WIDTH-1].
  - 011 SHR: q <= {sr_in, q[WIDTH-1:1]}; cout <= old q[0].
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; cout <= old q[WIDTH-1].
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}; cout <= old q[0].
  - 110 INC: q <= q + 1 modulo 2^WIDTH. cout <= 1 only when old q was all ones (wrap to 0), else 0.
  - 111 DEC: q <= q - 1 modulo 2^WIDTH. cout <= 1 only when old q was 0 (wrap to all ones), else 0.
- Timing of cout:
  - cout is a one-cycle registered flag that reflects the most recent enabled operation.
  - It holds while en=0.
- Arithmetic:
  - Unsigned, WIDTH bits. No saturation.
  - The carry is never added back into q.
- Combinational outputs:
  - q_bar == ~q at all times, including immediately after reset: ~RESET_VALUE.
  - zero tracks q combinationally; no extra latency.
- Mode changes:
  - Any mode may follow any mode on consecutive cycles. No pipeline state exists beyond q and cout.
- Illegal or unknown inputs:
  - X on mode while en=1 and reset=0 gives an undefined result.
  - X on mode while en=0 or reset=1 must not disturb state.
- Implementation constraints:
  - Flip-flops only; no latches.
  - Single always_ff for q and cout; q_bar and zero via continuous assignment.

Test Plan:
- Reset (WIDTH=8, RESET_VALUE=8'hA5): reset=1 for one edge with mode=001, d=8'hFF, en=1 -> q=8'hA5, q_bar=8'h5A, cout=0, zero=0. Reset wins over load.
- Load and hold: LOAD d=8'h3C; then en=0 with mode=110 for 3 cycles -> q=8'h3C throughout, cout=0.
- Shifts: from q=8'b1000_0001:
  - SHL with sl_in=1 -> q=8'b0000_0011, cout=1.
  - Then SHR with sr_in=0 -> q=8'b0000_0001, cout=1.
  - Then SHR with sr_in=1 -> q=8'b1000_0000, cout=1.
- Rotates: from q=8'h81:
  - ROL -> q=8'h03, cout=1.
  - ROR -> q=8'h81, cout=1.
  - 8 consecutive ROL -> q returns to 8'h81.
- Count wrap: LOAD 8'hFE, then INC x2 -> q=8'hFF (cout=0), then q=8'h00 (cout=1, zero=1). Then DEC -> q=8'hFF, cout=1. Then DEC -> q=8'hFE, cout=0.
- Reset mid-count: INC every cycle from 8'h10; assert reset at the 4th edge -> q=8'hA5 at that edge (not 8'h14), cout=0. Counting resumes from 8'hA5 after reset deasserts.

Source files
------------

// File: rtl/universal_reg.sv
// Parametrised N-bit register with synchronous reset, enable, parallel load,
// shift, rotate and up/down count modes, plus a registered carry/serial-out bit.
module universal_reg #(
    parameter int unsigned          WIDTH       = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sl_in,
    input  logic             sr_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             cout,
    output logic             zero
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_INC  = 3'b110,
        M_DEC  = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             cout_q, cout_d;
    logic [WIDTH:0]   inc_sum;

    assign inc_sum = {1'b0, q_q} + (WIDTH+1)'(1);

    always_comb begin
        q_d    = q_q;
        cout_d = 1'b0;
        case (mode)
            M_HOLD: begin
                q_d    = q_q;
                cout_d = 1'b0;
            end
            M_LOAD: begin
                q_d    = d;
                cout_d = 1'b0;
            end
            M_SHL: begin
                q_d    = {q_q[WIDTH-2:0], sl_in};
                cout_d = q_q[WIDTH-1];
            end
            M_SHR: begin
                q_d    = {sr_in, q_q[WIDTH-1:1]};
                cout_d = q_q[0];
            end
            M_ROL: begin
                q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                cout_d = q_q[WIDTH-1];
            end
            M_ROR: begin
                q_d    = {q_q[0], q_q[WIDTH-1:1]};
                cout_d = q_q[0];
            end
            M_INC: begin
                q_d    = inc_sum[WIDTH-1:0];
                cout_d = inc_sum[WIDTH];
            end
            M_DEC: begin
                q_d    = q_q - WIDTH'(1);
                cout_d = (q_q == '0);
            end
            default: begin
                q_d    = q_q;
                cout_d = 1'b0;
            end
        endcase
    end

    // en gates the update so an unknown mode while disabled never reaches state
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= RESET_VALUE;
            cout_q <= 1'b0;
        end else if (en) begin
            q_q    <= q_d;
            cout_q <= cout_d;
        end
    end

    assign q     = q_q;
    assign cout  = cout_q;
    assign q_bar = ~q_q;
    assign zero  = (q_q == '0);

endmodule

// File: tb/tb_universal_reg.sv
// Self-checking bench for universal_reg: directed scenarios followed by random
// operations, all compared against an arithmetic reference model.
module tb_universal_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [7:0] d = 8'h00;
    logic       sl_in = 1'b0;
    logic       sr_in = 1'b0;
    logic [7:0] q, q_bar;
    logic       cout, zero;

    int checks = 0;
    int failures = 0;
    int unsigned m = 0;
    int unsigned c = 0;

    universal_reg #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sl_in (sl_in),
        .sr_in (sr_in),
        .q     (q),
        .q_bar (q_bar),
        .cout  (cout),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: register value as an integer in 0..255
    task automatic model(input logic r, input logic e, input logic [2:0] md,
                         input logic [7:0] dv, input logic sl, input logic sr);
        if (r) begin
            m = 8'hA5;
            c = 0;
        end else if (e) begin
            case (md)
                3'd0: c = 0;
                3'd1: begin m = dv; c = 0; end
                3'd2: begin c = m / 128; m = (m * 2 + sl) % 256; end
                3'd3: begin c = m % 2; m = m / 2 + sr * 128; end
                3'd4: begin c = m / 128; m = (m * 2 + c) % 256; end
                3'd5: begin c = m % 2; m = m / 2 + c * 128; end
                3'd6: begin c = (m == 255); m = (m + 1) % 256; end
                default: begin c = (m == 0); m = (m + 255) % 256; end
            endcase
        end
    endtask

    task automatic apply(input string tag, input logic r, input logic e, input logic [2:0] md,
                         input logic [7:0] dv, input logic sl, input logic sr);
        reset = r; en = e; mode = md; d = dv; sl_in = sl; sr_in = sr;
        @(posedge clk);
        #1;
        model(r, e, md, dv, sl, sr);
        chk({tag, ".q"},     {24'd0, q},     m);
        chk({tag, ".q_bar"}, {24'd0, q_bar}, (~m) & 32'hFF);
        chk({tag, ".cout"},  {31'd0, cout},  c);
        chk({tag, ".zero"},  {31'd0, zero},  {31'd0, m == 0});
    endtask

    initial begin
        // reset beats a simultaneous load
        apply("reset", 1, 1, 3'b001, 8'hFF, 0, 0);
        chk("reset_const", {24'd0, q}, 32'hA5);
        chk("reset_qbar_const", {24'd0, q_bar}, 32'h5A);

        apply("load", 0, 1, 3'b001, 8'h3C, 0, 0);
        for (int i = 0; i < 3; i++) apply("hold_en0", 0, 0, 3'b110, 8'h00, 1, 1);
        chk("hold_const", {24'd0, q}, 32'h3C);

        apply("load81", 0, 1, 3'b001, 8'h81, 0, 0);
        apply("shl", 0, 1, 3'b010, 8'h00, 1, 0);
        chk("shl_const", {24'd0, q}, 32'h03);
        apply("shr0", 0, 1, 3'b011, 8'h00, 0, 0);
        apply("shr1", 0, 1, 3'b011, 8'h00, 0, 1);
        chk("shr_const", {24'd0, q}, 32'h80);

        apply("load81b", 0, 1, 3'b001, 8'h81, 0, 0);
        apply("rol", 0, 1, 3'b100, 8'h00, 0, 0);
        apply("ror", 0, 1, 3'b101, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) apply("rol8", 0, 1, 3'b100, 8'h00, 0, 0);
        chk("rol8_const", {24'd0, q}, 32'h81);

        apply("loadFE", 0, 1, 3'b001, 8'hFE, 0, 0);
        apply("inc1", 0, 1, 3'b110, 8'h00, 0, 0);
        apply("inc_wrap", 0, 1, 3'b110, 8'h00, 0, 0);
        chk("inc_wrap_cout", {31'd0, cout}, 32'd1);
        apply("dec_wrap", 0, 1, 3'b111, 8'h00, 0, 0);
        apply("dec2", 0, 1, 3'b111, 8'h00, 0, 0);

        apply("load10", 0, 1, 3'b001, 8'h10, 0, 0);
        for (int i = 0; i < 3; i++) apply("inc_run", 0, 1, 3'b110, 8'h00, 0, 0);
        apply("reset_mid", 1, 1, 3'b110, 8'h00, 0, 0);
        chk("reset_mid_const", {24'd0, q}, 32'hA5);
        apply("inc_resume", 0, 1, 3'b110, 8'h00, 0, 0);

        // unknown mode must not disturb state while disabled or in reset
        apply("x_en0", 0, 0, 3'bxxx, 8'h00, 0, 0);
        apply("x_reset", 1, 1, 3'bxxx, 8'h00, 0, 0);

        for (int i = 0; i < 400; i++) begin
            apply("rand",
                  ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)),
                  8'($urandom),
                  1'($urandom),
                  1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
